// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART.
//
// Purpose:
//   Serialises TX payloads as start / DATA_BITS (LSB first) / optional parity /
//   STOP_BITS frames and deserialises RX frames with mid-bit oversampled
//   sampling, a false-start filter, parity and framing error detection.
//   The TX and RX paths share only the tick generator; they never interact.
//
// Parameters:
//   CLK_HZ, BAUD     clock and line rate; tick divider = round(CLK_HZ/(BAUD*OVERSAMPLE)), min 1
//   OVERSAMPLE       ticks per bit (even, >= 8)
//   DATA_BITS        payload width (5..9)
//   PARITY           0 = none, 1 = even, 2 = odd
//   STOP_BITS        1 or 2
//
// Ports:
//   CLK_50MHZ        system clock
//   RST              asynchronous active-high reset
//   RX               serial input (idle high, asynchronous)
//   TX               serial output (idle high)
//   FLOW             1 = peer not ready; blocks acceptance of a new TX frame
//   DATA_IN          TX payload, captured when a write is accepted
//   TRG_WRITE        TX request (level or pulse)
//   TX_BUSY          high while a TX frame is in progress
//   TX_DONE          1-cycle pulse when the TX frame ends
//   DATA_OUT         last received payload
//   RX_VALID         1-cycle pulse, DATA_OUT updated
//   RX_PARITY_ERR    qualifies RX_VALID: parity mismatch
//   RX_FRAME_ERR     qualifies RX_VALID: first stop bit sampled low
module uart_param #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 CLK_50MHZ,
  input  logic                 RST,
  input  logic                 RX,
  output logic                 TX,
  input  logic                 FLOW,
  input  logic [DATA_BITS-1:0] DATA_IN,
  input  logic                 TRG_WRITE,
  output logic                 TX_BUSY,
  output logic                 TX_DONE,
  output logic [DATA_BITS-1:0] DATA_OUT,
  output logic                 RX_VALID,
  output logic                 RX_PARITY_ERR,
  output logic                 RX_FRAME_ERR
);

  localparam int DIV_RAW = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W    = $clog2(OVERSAMPLE);
  localparam int BIT_W   = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Tick generator: free-running, one-cycle tick every DIV clocks.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] r_div;
  logic             w_tick;

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) r_div <= '0;
    else     r_div <= w_tick ? '0 : r_div + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------------------
  state_t                 r_tx_state, w_tx_state_next;
  logic [OS_W-1:0]        r_tx_os, w_tx_os_next;
  logic [BIT_W-1:0]       r_tx_bit, w_tx_bit_next;
  logic [DATA_BITS-1:0]   r_tx_data;
  logic                   r_tx_par;
  logic                   r_tx;
  logic                   r_tx_done;
  logic                   w_tx_accept;
  logic                   w_tx_bit_end;
  logic                   w_tx_line;

  // r_tx_done gating means a new frame is taken no earlier than the cycle
  // after the done pulse.
  assign w_tx_accept  = (r_tx_state == S_IDLE) && TRG_WRITE && !FLOW && !r_tx_done;
  assign w_tx_bit_end = w_tick && (r_tx_os == OS_LAST);

  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_bit_next   = r_tx_bit;
    w_tx_os_next    = w_tx_bit_end ? '0 : (w_tick ? r_tx_os + 1'b1 : r_tx_os);
    w_tx_line       = 1'b1;

    case (r_tx_state)
      S_IDLE: begin
        w_tx_os_next  = '0;
        w_tx_bit_next = '0;
        if (w_tx_accept) w_tx_state_next = S_START;
      end
      S_START: begin
        if (w_tx_bit_end) begin
          w_tx_state_next = S_DATA;
          w_tx_bit_next   = '0;
        end
      end
      S_DATA: begin
        if (w_tx_bit_end) begin
          if (r_tx_bit == DATA_LAST) begin
            w_tx_bit_next   = '0;
            w_tx_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_tx_bit_next = r_tx_bit + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_tx_bit_end) begin
          w_tx_state_next = S_STOP;
          w_tx_bit_next   = '0;
        end
      end
      S_STOP: begin
        if (w_tx_bit_end) begin
          if (r_tx_bit == STOP_LAST) w_tx_state_next = S_IDLE;
          else                       w_tx_bit_next   = r_tx_bit + 1'b1;
        end
      end
      default: w_tx_state_next = S_IDLE;
    endcase

    // The line level is registered from the next state so TX is glitch-free.
    case (w_tx_state_next)
      S_START:  w_tx_line = 1'b0;
      S_DATA:   w_tx_line = r_tx_data[w_tx_bit_next];
      S_PARITY: w_tx_line = r_tx_par;
      default:  w_tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      r_tx_state <= S_IDLE;
      r_tx_os    <= '0;
      r_tx_bit   <= '0;
      r_tx_data  <= '0;
      r_tx_par   <= 1'b0;
      r_tx       <= 1'b1;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_tx_os    <= w_tx_os_next;
      r_tx_bit   <= w_tx_bit_next;
      r_tx       <= w_tx_line;
      r_tx_done  <= (r_tx_state == S_STOP) && (w_tx_state_next == S_IDLE);
      if (w_tx_accept) begin
        r_tx_data <= DATA_IN;
        r_tx_par  <= (PARITY == 2) ? ~(^DATA_IN) : (^DATA_IN);
      end
    end
  end

  assign TX      = r_tx;
  assign TX_DONE = r_tx_done;
  assign TX_BUSY = (r_tx_state != S_IDLE);

  // ---------------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------------
  logic                 r_rx_meta, r_rx_sync, r_rx_prev;
  state_t               r_rx_state, w_rx_state_next;
  logic [OS_W-1:0]      r_rx_os, w_rx_os_next;
  logic [BIT_W-1:0]     r_rx_bit, w_rx_bit_next;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par_err;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid, r_rx_perr, r_rx_ferr;
  logic                 w_rx_fall;
  logic                 w_rx_mid_start;
  logic                 w_rx_bit_end;
  logic                 w_rx_par_expect;

  assign w_rx_fall       = r_rx_prev && !r_rx_sync;
  assign w_rx_mid_start  = w_tick && (r_rx_os == OS_HALF);
  assign w_rx_bit_end    = w_tick && (r_rx_os == OS_LAST);
  assign w_rx_par_expect = (PARITY == 2) ? ~(^r_rx_shift) : (^r_rx_shift);

  always_comb begin
    w_rx_state_next = r_rx_state;
    w_rx_bit_next   = r_rx_bit;
    w_rx_os_next    = w_rx_bit_end ? '0 : (w_tick ? r_rx_os + 1'b1 : r_rx_os);

    case (r_rx_state)
      S_IDLE: begin
        w_rx_os_next  = '0;
        w_rx_bit_next = '0;
        if (w_rx_fall) w_rx_state_next = S_START;
      end
      S_START: begin
        // Half a bit in: restart the counter so later samples land mid-bit.
        w_rx_os_next = w_rx_mid_start ? '0 : (w_tick ? r_rx_os + 1'b1 : r_rx_os);
        if (w_rx_mid_start) begin
          w_rx_state_next = r_rx_sync ? S_IDLE : S_DATA;
          w_rx_bit_next   = '0;
        end
      end
      S_DATA: begin
        if (w_rx_bit_end) begin
          if (r_rx_bit == DATA_LAST) begin
            w_rx_bit_next   = '0;
            w_rx_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_rx_bit_next = r_rx_bit + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_rx_bit_end) w_rx_state_next = S_STOP;
      end
      S_STOP: begin
        // Only the first stop bit is checked; IDLE resumes right after it.
        if (w_rx_bit_end) w_rx_state_next = S_IDLE;
      end
      default: w_rx_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      r_rx_meta    <= 1'b1;
      r_rx_sync    <= 1'b1;
      r_rx_prev    <= 1'b1;
      r_rx_state   <= S_IDLE;
      r_rx_os      <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_par_err <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_perr    <= 1'b0;
      r_rx_ferr    <= 1'b0;
    end else begin
      r_rx_meta  <= RX;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_state <= w_rx_state_next;
      r_rx_os    <= w_rx_os_next;
      r_rx_bit   <= w_rx_bit_next;
      r_rx_valid <= 1'b0;
      r_rx_perr  <= 1'b0;
      r_rx_ferr  <= 1'b0;

      if (r_rx_state == S_START) r_rx_par_err <= 1'b0;
      if (r_rx_state == S_DATA && w_rx_bit_end)
        r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
      if (r_rx_state == S_PARITY && w_rx_bit_end)
        r_rx_par_err <= r_rx_sync ^ w_rx_par_expect;
      if (r_rx_state == S_STOP && w_rx_bit_end) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
        r_rx_perr  <= (PARITY != 0) && r_rx_par_err;
        r_rx_ferr  <= !r_rx_sync;
      end
    end
  end

  assign DATA_OUT      = r_rx_data;
  assign RX_VALID      = r_rx_valid;
  assign RX_PARITY_ERR = r_rx_perr;
  assign RX_FRAME_ERR  = r_rx_ferr;

endmodule

// File: doc/uart_param.md
Name: uart_param

Overview:
- Parametrised full-duplex UART. Successor to the fixed 8N1 UART.
- Configurable data width, parity, stop bits, baud and oversampling; adds parity and framing error detection, a false-start filter and transmit flow-control gating.
- Connects between the scoreboard control logic and the board serial pins; drives TX and samples RX.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
OVERSAMPLE, 16, RX ticks per bit; even, >=8
DATA_BITS, 8, payload bits per frame, 5..9
PARITY, 0, 0=none 1=even 2=odd
STOP_BITS, 1, 1 or 2

Ports:
CLK_50MHZ  in  1  system clock
RST  in  1  asynchronous reset, active-high
RX  in  1  serial input, idle high, asynchronous to clock
TX  out  1  serial output, idle high
FLOW  in  1  1 = peer not ready; holds the start of a new TX frame
DATA_IN  in  DATA_BITS  TX payload, sampled on accepted TRG_WRITE
TRG_WRITE  in  1  TX request, level or pulse
TX_BUSY  out  1  high from the cycle after accept until frame end
TX_DONE  out  1  1-cycle pulse after the last stop bit
DATA_OUT  out  DATA_BITS  last received payload, held until next frame
RX_VALID  out  1  1-cycle pulse, DATA_OUT updated this cycle
RX_PARITY_ERR  out  1  qualifies RX_VALID; high when parity mismatches
RX_FRAME_ERR  out  1  qualifies RX_VALID; high when a stop bit is sampled 0

Behaviour:

Reset (async):
- TX=1; all other outputs 0.
- Both FSMs go to IDLE; counters clear.
- Reset mid-frame aborts the frame with no pulses; TX returns high immediately.

Tick generator:
- DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), minimum 1.
- Free-running counter produces a 1-cycle tick every DIV clocks.
- One bit period = OVERSAMPLE ticks.

TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
- Accept when state=IDLE and TRG_WRITE=1 and FLOW=0. On accept, latch DATA_IN and align to the next tick.
- TRG_WRITE while busy or while FLOW=1 is ignored; there is no queueing.
- FLOW is checked only at accept. A frame already started always completes.
- Bit order: start 0, data LSB first, parity, then STOP_BITS ones. Each bit is held OVERSAMPLE ticks.
- TX_DONE pulses on the cycle the FSM returns to IDLE; TX_BUSY falls the same cycle.
- A new frame can be accepted on the cycle after TX_DONE.

RX path:
- RX passes through a 2-flop synchroniser, preset to 1 on reset.
- FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- IDLE: a 1->0 transition starts the START state. The tick counter resets so sampling lands at OVERSAMPLE/2.
- START: at mid-bit, if the sample is 1, treat as a glitch and return to IDLE with no output. Otherwise proceed.
- DATA/PARITY: sample each bit at mid-bit, OVERSAMPLE ticks apart; shift in LSB first.
- STOP: sample only the first stop bit.
- At the stop sample: DATA_OUT <= payload, RX_VALID=1, and both error flags are set for that single cycle.
- A frame error still delivers the data.
- Return to IDLE right after the stop sample. A back-to-back start edge is detected from the next cycle.
- Overrun: no buffer; the next frame overwrites DATA_OUT.

Parity and width:
- Even parity: XOR of data bits; odd parity: its inverse.
- When PARITY=0, RX_PARITY_ERR stays 0.
- DATA_BITS=9 works with parity enabled (11-bit frame plus stop bits).

Simultaneous events: TX and RX are fully independent; concurrent activity has no interaction.

Test Plan:
Bench parameters CLK_HZ=50000000, BAUD=3125000, OVERSAMPLE=16 (DIV=1, 16 clocks/bit); TX looped to RX through one register.

1. Default 8N1: write 8'h55 -> TX shows 0,1,0,1,0,1,0,1,0,1 at 16-clock spacing. RX_VALID pulses once with DATA_OUT=8'h55 and no errors. TX_DONE pulses 160±2 clocks after accept.
2. PARITY=1, STOP_BITS=2: send 8'hA3 -> parity bit 0 and frame length 12 bits. Inject a flipped parity bit -> RX_VALID with RX_PARITY_ERR=1 and DATA_OUT=8'hA3.
3. Drive RX low for the stop bit of frame 8'h0F -> RX_VALID=1, RX_FRAME_ERR=1, DATA_OUT=8'h0F.
4. 4-clock low glitch on an idle RX -> no RX_VALID, FSM back in IDLE. A valid frame 8'hC8 sent immediately after is received correctly.
5. FLOW=1 with TRG_WRITE held -> TX stays 1 and TX_BUSY=0. Release FLOW -> frame starts within DIV+1 cycles. Raising FLOW mid-frame does not truncate the frame.
6. Assert RST during bit 4 of a TX frame -> TX=1 next edge, no TX_DONE. A following write of 8'h81 completes and loops back correctly.
